// File: rtl/rd_slot_timer_pkg.sv
// Shared types and index-width helper for the read-slot timeout tracker.
// RD_SLOT_TIMER_PRESCALER_EN (set at build) selects the internal tick prescaler.
package rd_slot_timer_pkg;

  localparam int unsigned DefNumSlots = 4;
  localparam int unsigned DefCntWidth = 8;

  // Index width that stays legal for a single-slot array.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DefIdxWidth = idx_width(DefNumSlots);

  typedef struct packed {
    logic                   busy;
    logic                   timeout;
    logic [DefCntWidth-1:0] counter;
    logic [DefCntWidth-1:0] budget;
  } slot_state_t;

endpackage

// File: rtl/rd_slot_counter.sv
// One tracked read slot: busy/counter/budget/timeout with alloc > retire > reload > decrement.
// Result is registered (one cycle); no backpressure, commands are pre-qualified by the parent.
module rd_slot_counter #(
  parameter int CntWidth = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc,
  input  logic [CntWidth-1:0] alloc_budget,
  input  logic                retire,
  input  logic                reload,
  input  logic                tick,
  input  logic                clear,
  output logic                busy,
  output logic [CntWidth-1:0] counter,
  output logic                timeout
);

  typedef struct packed {
    logic                busy;
    logic                timeout;
    logic [CntWidth-1:0] counter;
    logic [CntWidth-1:0] budget;
  } slot_reg_t;

  slot_reg_t st;
  slot_reg_t nxt;

  always_comb begin
    nxt = st;
    if (alloc) begin
      nxt.busy    = 1'b1;
      nxt.counter = alloc_budget;
      nxt.budget  = alloc_budget;
      nxt.timeout = (alloc_budget == '0);
    end else begin
      // A same-cycle timeout set below overrides this clear.
      if (clear) nxt.timeout = 1'b0;
      if (retire) begin
        nxt.busy = 1'b0;
      end else if (reload) begin
        nxt.counter = st.budget;
      end else if (tick && st.busy) begin
        if (st.counter == '0) begin
          nxt.timeout = 1'b1;
        end else begin
          nxt.counter = st.counter - 1'b1;
          if (st.counter == CntWidth'(1)) nxt.timeout = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) st <= '0;
    else     st <= nxt;
  end

  assign busy    = st.busy;
  assign counter = st.counter;
  assign timeout = st.timeout;

endmodule

// File: rtl/rd_slot_timer_array.sv
// Per-slot AXI read timeout tracker; RD_SLOT_TIMER_PRESCALER_EN builds the internal tick divider.
// Outputs registered one cycle after the causing input; no backpressure (alloc to a busy slot is rejected).
module rd_slot_timer_array
  import rd_slot_timer_pkg::*;
#(
  parameter int NumSlots   = 4,
  parameter int CntWidth   = 8,
  parameter int PrescWidth = 4,
  parameter int IdxWidth   = idx_width(NumSlots)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         tick_i,
  input  logic [PrescWidth-1:0]        prescale_i,
  input  logic                         alloc_i,
  input  logic [IdxWidth-1:0]          alloc_idx_i,
  input  logic [CntWidth-1:0]          alloc_budget_i,
  input  logic [IdxWidth-1:0]          head_idx_i,
  input  logic                         r_hs_i,
  input  logic                         r_last_i,
  input  logic                         beat_mode_i,
  input  logic [NumSlots-1:0]          clr_timeout_i,
  output logic [NumSlots-1:0]          busy_o,
  output logic [NumSlots*CntWidth-1:0] counter_o,
  output logic [NumSlots-1:0]          timeout_o,
  output logic                         timeout_any_o,
  output logic                         alloc_err_o,
  output logic                         retire_o
);

  logic tick;

`ifdef RD_SLOT_TIMER_PRESCALER_EN
  logic [PrescWidth-1:0] presc_cnt;
  logic                  unused_tick;

  assign unused_tick = tick_i;
  // >= so a prescale value lowered below the running count still ticks.
  assign tick = (presc_cnt >= prescale_i);

  always_ff @(posedge clk_i) begin
    if (rst_i)     presc_cnt <= '0;
    else if (tick) presc_cnt <= '0;
    else           presc_cnt <= PrescWidth'(presc_cnt + 1'b1);
  end
`else
  logic [PrescWidth-1:0] unused_prescale;

  assign unused_prescale = prescale_i;
  assign tick            = tick_i;
`endif

  logic [NumSlots-1:0] busy;
  logic [NumSlots-1:0] timeout;
  logic [NumSlots-1:0] retire_hit;
  logic [NumSlots-1:0] alloc_ok;
  logic                head_last;
  logic                head_beat;

  assign head_last = r_hs_i && r_last_i;
  assign head_beat = beat_mode_i && r_hs_i && !r_last_i;

  // Out-of-range indices match no slot, so they are rejected / ignored naturally.
  for (genvar s = 0; s < NumSlots; s++) begin : g_slot
    logic head_sel;
    logic alloc_sel;
    logic reload;

    assign head_sel      = (head_idx_i == IdxWidth'(s));
    assign alloc_sel     = alloc_i && (alloc_idx_i == IdxWidth'(s));
    assign retire_hit[s] = head_sel && head_last && busy[s];
    assign reload        = head_sel && head_beat && busy[s];
    assign alloc_ok[s]   = alloc_sel && (!busy[s] || retire_hit[s]);

    rd_slot_counter #(
      .CntWidth(CntWidth)
    ) u_slot (
      .clk         (clk_i),
      .rst         (rst_i),
      .alloc       (alloc_ok[s]),
      .alloc_budget(alloc_budget_i),
      .retire      (retire_hit[s]),
      .reload      (reload),
      .tick        (tick),
      .clear       (clr_timeout_i[s]),
      .busy        (busy[s]),
      .counter     (counter_o[s*CntWidth +: CntWidth]),
      .timeout     (timeout[s])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_err_o <= 1'b0;
      retire_o    <= 1'b0;
    end else begin
      alloc_err_o <= alloc_i && !(|alloc_ok);
      retire_o    <= |retire_hit;
    end
  end

  assign busy_o        = busy;
  assign timeout_o     = timeout;
  assign timeout_any_o = |timeout;

endmodule
